// File: rtl/mem_access_stage.sv
// mem_access_stage
//   Registered MEM stage between EX and WB. Loads and stores go out on a
//   req/ack data-memory bus. Non-memory ops reach WB one cycle later.
//   Misaligned accesses are dropped with a misalign_o pulse.
//   A bus that never acks is abandoned after TIMEOUT cycles, with a bus_err_o pulse.
//
//   Ports
//     clk, rst         clock, synchronous active-high reset
//     valid_i ..       EX-side instruction: aluop_i, funct3_i, rd_we_i,
//     st_data_i        rd_addr_i, rd_data_i (ALU result / address), st_data_i
//     mem_*            data-memory bus: req/we/addr/wdata/be out, ack/rdata in
//     stall_o          combinational hold request to the upstream stage
//     rd_we/addr/data  registered writeback to WB
//     misalign_o       one-cycle pulse, misaligned access dropped
//     bus_err_o        one-cycle pulse, bus timeout
module mem_access_stage #(
  parameter int XLEN    = 32,
  parameter int REG_AW  = 5,
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  input  logic [6:0]        aluop_i,
  input  logic [2:0]        funct3_i,
  input  logic              rd_we_i,
  input  logic [REG_AW-1:0] rd_addr_i,
  input  logic [XLEN-1:0]   rd_data_i,
  input  logic [XLEN-1:0]   st_data_i,
  output logic              mem_req,
  output logic              mem_we,
  output logic [XLEN-1:0]   mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [3:0]        mem_be,
  input  logic              mem_ack,
  input  logic [XLEN-1:0]   mem_rdata,
  output logic              stall_o,
  output logic              rd_we,
  output logic [REG_AW-1:0] rd_addr,
  output logic [XLEN-1:0]   rd_data,
  output logic              misalign_o,
  output logic              bus_err_o
);

  localparam logic [6:0]      OP_LOAD  = 7'b0000011;
  localparam logic [6:0]      OP_STORE = 7'b0100011;
  localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT - 1);
  localparam logic [TO_W-1:0] TO_ONE   = TO_W'(1);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_t;

  // funct3[1:0] gives the access size: 00 byte, 01 half, anything else word.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] lo);
    case (f3[1:0])
      2'b00:   is_misaligned = 1'b0;
      2'b01:   is_misaligned = lo[0];
      default: is_misaligned = (lo != 2'b00);
    endcase
  endfunction

  function automatic logic [3:0] byte_en(input logic [2:0] f3, input logic [1:0] lo);
    case (f3[1:0])
      2'b00:   byte_en = 4'b0001 << lo;
      2'b01:   byte_en = 4'b0011 << {lo[1], 1'b0};
      default: byte_en = 4'b1111;
    endcase
  endfunction

  // Replicate the store datum into every lane so the byte enables select it.
  function automatic logic [XLEN-1:0] lane_wdata(input logic [2:0] f3, input logic [XLEN-1:0] d);
    case (f3[1:0])
      2'b00:   lane_wdata = {4{d[7:0]}};
      2'b01:   lane_wdata = {2{d[15:0]}};
      default: lane_wdata = d;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] fmt_load(input logic [2:0] f3, input logic [1:0] lo,
                                               input logic [XLEN-1:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    case (lo)
      2'b00:   b = w[7:0];
      2'b01:   b = w[15:8];
      2'b10:   b = w[23:16];
      2'b11:   b = w[31:24];
      default: b = 8'h00;
    endcase
    h = lo[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  fmt_load = {{24{b[7]}}, b};
      3'b001:  fmt_load = {{16{h[15]}}, h};
      3'b100:  fmt_load = {24'h000000, b};
      3'b101:  fmt_load = {16'h0000, h};
      default: fmt_load = w;
    endcase
  endfunction

  state_t            state_r, state_s;
  logic [TO_W-1:0]   cnt_r, cnt_s;
  logic              is_load_r, is_load_s;
  logic [2:0]        funct3_r, funct3_s;
  logic [1:0]        lo_r, lo_s;
  logic              wb_we_r, wb_we_s;
  logic [REG_AW-1:0] wb_addr_r, wb_addr_s;
  logic              mem_req_s, mem_we_s;
  logic [XLEN-1:0]   mem_addr_s, mem_wdata_s;
  logic [3:0]        mem_be_s;
  logic              rd_we_s;
  logic [REG_AW-1:0] rd_addr_s;
  logic [XLEN-1:0]   rd_data_s;
  logic              misalign_s, bus_err_s;
  logic              op_load_s, op_store_s;

  assign op_load_s  = (aluop_i == OP_LOAD);
  assign op_store_s = (aluop_i == OP_STORE);

  // Next-state, next-output and stall decode for the IDLE/BUSY controller.
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    is_load_s   = is_load_r;
    funct3_s    = funct3_r;
    lo_s        = lo_r;
    wb_we_s     = wb_we_r;
    wb_addr_s   = wb_addr_r;
    mem_req_s   = mem_req;
    mem_we_s    = mem_we;
    mem_addr_s  = mem_addr;
    mem_wdata_s = mem_wdata;
    mem_be_s    = mem_be;
    rd_we_s     = 1'b0;
    rd_addr_s   = rd_addr;
    rd_data_s   = rd_data;
    misalign_s  = 1'b0;
    bus_err_s   = 1'b0;
    stall_o     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (valid_i && (op_load_s || op_store_s)) begin
          stall_o = 1'b1;
          if (is_misaligned(funct3_i, rd_data_i[1:0])) begin
            misalign_s = 1'b1;
          end else begin
            state_s     = ST_BUSY;
            cnt_s       = {TO_W{1'b0}};
            is_load_s   = op_load_s;
            funct3_s    = funct3_i;
            lo_s        = rd_data_i[1:0];
            wb_we_s     = rd_we_i;
            wb_addr_s   = rd_addr_i;
            mem_req_s   = 1'b1;
            mem_we_s    = op_store_s;
            mem_addr_s  = {rd_data_i[XLEN-1:2], 2'b00};
            mem_be_s    = byte_en(funct3_i, rd_data_i[1:0]);
            mem_wdata_s = op_store_s ? lane_wdata(funct3_i, st_data_i) : {XLEN{1'b0}};
          end
        end else if (valid_i) begin
          rd_we_s   = rd_we_i;
          rd_addr_s = rd_addr_i;
          rd_data_s = rd_data_i;
        end else begin
          rd_we_s = 1'b0;
        end
      end
      ST_BUSY: begin
        // The timeout cycle also releases upstream: that instruction is abandoned.
        stall_o = ~mem_ack & (cnt_r != TO_LAST);
        if (mem_ack || (cnt_r == TO_LAST)) begin
          state_s     = ST_IDLE;
          mem_req_s   = 1'b0;
          mem_we_s    = 1'b0;
          mem_addr_s  = {XLEN{1'b0}};
          mem_wdata_s = {XLEN{1'b0}};
          mem_be_s    = 4'b0000;
        end else begin
          cnt_s = cnt_r + TO_ONE;
        end
        if (mem_ack && is_load_r) begin
          rd_we_s   = wb_we_r;
          rd_addr_s = wb_addr_r;
          rd_data_s = fmt_load(funct3_r, lo_r, mem_rdata);
        end else if (!mem_ack && (cnt_r == TO_LAST)) begin
          bus_err_s = 1'b1;
        end else begin
          rd_we_s = 1'b0;
        end
      end
      default: begin
        state_s   = ST_IDLE;
        mem_req_s = 1'b0;
        mem_be_s  = 4'b0000;
      end
    endcase
  end

  // State and registered-output update, synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      cnt_r      <= {TO_W{1'b0}};
      is_load_r  <= 1'b0;
      funct3_r   <= 3'b000;
      lo_r       <= 2'b00;
      wb_we_r    <= 1'b0;
      wb_addr_r  <= {REG_AW{1'b0}};
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= {XLEN{1'b0}};
      mem_wdata  <= {XLEN{1'b0}};
      mem_be     <= 4'b0000;
      rd_we      <= 1'b0;
      rd_addr    <= {REG_AW{1'b0}};
      rd_data    <= {XLEN{1'b0}};
      misalign_o <= 1'b0;
      bus_err_o  <= 1'b0;
    end else begin
      state_r    <= state_s;
      cnt_r      <= cnt_s;
      is_load_r  <= is_load_s;
      funct3_r   <= funct3_s;
      lo_r       <= lo_s;
      wb_we_r    <= wb_we_s;
      wb_addr_r  <= wb_addr_s;
      mem_req    <= mem_req_s;
      mem_we     <= mem_we_s;
      mem_addr   <= mem_addr_s;
      mem_wdata  <= mem_wdata_s;
      mem_be     <= mem_be_s;
      rd_we      <= rd_we_s;
      rd_addr    <= rd_addr_s;
      rd_data    <= rd_data_s;
      misalign_o <= misalign_s;
      bus_err_o  <= bus_err_s;
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
module tb_mem_access_stage;
  localparam int TIMEOUT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid_i = 1'b0;
  logic [6:0]  aluop_i = 7'd0;
  logic [2:0]  funct3_i = 3'd0;
  logic        rd_we_i = 1'b0;
  logic [4:0]  rd_addr_i = 5'd0;
  logic [31:0] rd_data_i = 32'd0;
  logic [31:0] st_data_i = 32'd0;
  logic        mem_req, mem_we, mem_ack = 1'b0;
  logic [31:0] mem_addr, mem_wdata, mem_rdata = 32'd0;
  logic [3:0]  mem_be;
  logic        stall_o, rd_we, misalign_o, bus_err_o;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;

  int checks = 0;
  int failures = 0;

  // kind: 0 = writeback, 1 = misalign pulse, 2 = bus error pulse
  typedef struct {
    int          kind;
    logic [4:0]  ra;
    logic [31:0] d;
  } ev_t;
  ev_t exp_q[$];

  mem_access_stage #(.XLEN(32), .REG_AW(5), .TIMEOUT(TIMEOUT), .TO_W(3)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .aluop_i(aluop_i), .funct3_i(funct3_i),
    .rd_we_i(rd_we_i), .rd_addr_i(rd_addr_i), .rd_data_i(rd_data_i), .st_data_i(st_data_i),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .stall_o(stall_o),
    .rd_we(rd_we), .rd_addr(rd_addr), .rd_data(rd_data), .misalign_o(misalign_o),
    .bus_err_o(bus_err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference load result computed arithmetically from lane position and extension rule.
  function automatic logic [31:0] model_load(input logic [2:0] f3, input int lo, input logic [31:0] w);
    logic [31:0] b, h;
    b = (w >> (8 * lo)) & 32'hFF;
    h = (w >> (16 * (lo / 2))) & 32'hFFFF;
    case (f3)
      3'b000:  return (b >= 32'd128) ? b + 32'hFFFF_FF00 : b;
      3'b001:  return (h >= 32'd32768) ? h + 32'hFFFF_0000 : h;
      3'b100:  return b;
      3'b101:  return h;
      default: return w;
    endcase
  endfunction

  // Monitor: pops the scoreboard whenever the DUT presents a WB/misalign/bus-error event.
  initial begin
    ev_t e;
    int  kind;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (!mem_req) chk("be_zero_when_idle", 32'(mem_be), 32'd0);
        if (rd_we || misalign_o || bus_err_o) begin
          kind = rd_we ? 0 : (misalign_o ? 1 : 2);
          chk("single_event", 32'(rd_we) + 32'(misalign_o) + 32'(bus_err_o), 32'd1);
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_event actual_kind=%0d required=none", kind);
          end else begin
            e = exp_q.pop_front();
            chk("event_kind", 32'(kind), 32'(e.kind));
            if (kind == 0) begin
              chk("wb_addr", 32'(rd_addr), 32'(e.ra));
              chk("wb_data", rd_data, e.d);
            end
          end
        end
      end
    end
  end

  // Drives one instruction starting at a negedge and returns at a negedge with the DUT IDLE.
  // ack_at: BUSY cycle index on which mem_ack is raised; negative means never.
  task automatic run_op(input logic [6:0] op, input logic [2:0] f3, input logic we,
                        input logic [4:0] ra, input logic [31:0] a, input logic [31:0] st,
                        input logic [31:0] rdata, input int ack_at);
    bit is_ld, is_st, done;
    int sz, cyc;
    logic [31:0] eaddr, ebe, ewd;
    is_ld = (op == 7'b0000011);
    is_st = (op == 7'b0100011);
    sz = (f3[1:0] == 2'b00) ? 1 : ((f3[1:0] == 2'b01) ? 2 : 4);
    valid_i = 1'b1; aluop_i = op; funct3_i = f3; rd_we_i = we; rd_addr_i = ra;
    rd_data_i = a; st_data_i = st; mem_ack = 1'b0;
    #1;
    if (!(is_ld || is_st)) begin
      chk("nonmem_stall", 32'(stall_o), 32'd0);
      if (we) exp_q.push_back('{kind: 0, ra: ra, d: a});
      @(negedge clk);
      chk("nonmem_rd_we", 32'(rd_we), 32'(we));
      chk("nonmem_no_req", 32'(mem_req), 32'd0);
    end else if ((a % sz) != 0) begin
      chk("mis_stall", 32'(stall_o), 32'd1);
      exp_q.push_back('{kind: 1, ra: 5'd0, d: 32'd0});
      @(negedge clk);
      chk("mis_pulse", 32'(misalign_o), 32'd1);
      chk("mis_no_req", 32'(mem_req), 32'd0);
      chk("mis_rd_we", 32'(rd_we), 32'd0);
      valid_i = 1'b0;
      #1 chk("mis_stall_drop", 32'(stall_o), 32'd0);
    end else begin
      chk("mem_stall_idle", 32'(stall_o), 32'd1);
      eaddr = a - (a % 4);
      ebe   = ((32'd1 << sz) - 32'd1) << (a % 4);
      ewd   = (sz == 1) ? (st & 32'hFF) * 32'h0101_0101 :
              ((sz == 2) ? (st & 32'hFFFF) * 32'h0001_0001 : st);
      @(negedge clk);
      chk("issue_rd_we", 32'(rd_we), 32'd0);
      cyc = 0;
      done = 1'b0;
      while (!done) begin
        chk("busy_req", 32'(mem_req), 32'd1);
        chk("busy_addr", mem_addr, eaddr);
        chk("busy_we", 32'(mem_we), 32'(is_st));
        if (is_st) begin
          chk("busy_be", 32'(mem_be), ebe);
          chk("busy_wdata", mem_wdata, ewd);
        end
        // Inputs are ignored in BUSY, so scramble them.
        rd_data_i = $urandom; st_data_i = $urandom; rd_addr_i = 5'($urandom);
        funct3_i = 3'($urandom); rd_we_i = 1'($urandom);
        if (ack_at == cyc) begin
          mem_ack = 1'b1; mem_rdata = rdata;
          #1 chk("ack_stall", 32'(stall_o), 32'd0);
          if (is_ld && we) exp_q.push_back('{kind: 0, ra: ra, d: model_load(f3, int'(a % 4), rdata)});
          @(negedge clk);
          mem_ack = 1'b0; mem_rdata = $urandom;
          chk("done_req", 32'(mem_req), 32'd0);
          chk("done_rd_we", 32'(rd_we), 32'(is_ld && we));
          done = 1'b1;
        end else if (cyc == TIMEOUT - 1) begin
          mem_rdata = $urandom;
          #1 chk("timeout_stall", 32'(stall_o), 32'd0);
          exp_q.push_back('{kind: 2, ra: 5'd0, d: 32'd0});
          @(negedge clk);
          chk("timeout_req", 32'(mem_req), 32'd0);
          chk("timeout_err", 32'(bus_err_o), 32'd1);
          chk("timeout_rd_we", 32'(rd_we), 32'd0);
          done = 1'b1;
        end else begin
          mem_rdata = $urandom;
          #1 chk("busy_stall", 32'(stall_o), 32'd1);
          @(negedge clk);
          cyc++;
        end
      end
    end
    valid_i = 1'b0;
  endtask

  initial begin
    logic [6:0]  op;
    logic [31:0] a;
    int          r, ack;
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_be", 32'(mem_be), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_rd_we", 32'(rd_we), 32'd0);
    chk("rst_rd_addr", 32'(rd_addr), 32'd0);
    chk("rst_rd_data", rd_data, 32'd0);
    chk("rst_misalign", 32'(misalign_o), 32'd0);
    chk("rst_bus_err", 32'(bus_err_o), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Non-memory pass-through
    run_op(7'b0110011, 3'b000, 1'b1, 5'd5, 32'h1234, 32'd0, 32'd0, 0);
    chk("pass_rd_addr", 32'(rd_addr), 32'd5);
    chk("pass_rd_data", rd_data, 32'h1234);

    // LB / LBU at 0x103, ack on the third BUSY cycle
    run_op(7'b0000011, 3'b000, 1'b1, 5'd7, 32'h103, 32'd0, 32'h80FF_FF7F, 2);
    chk("lb_value", rd_data, 32'hFFFF_FF80);
    run_op(7'b0000011, 3'b100, 1'b1, 5'd8, 32'h103, 32'd0, 32'h80FF_FF7F, 2);
    chk("lbu_value", rd_data, 32'h0000_0080);

    // SH at 0x202
    run_op(7'b0100011, 3'b001, 1'b1, 5'd9, 32'h202, 32'hAAAA_BEEF, 32'd0, 1);

    // Misaligned LW
    run_op(7'b0000011, 3'b010, 1'b1, 5'd10, 32'h6, 32'd0, 32'd0, 0);

    // Timeout, then a late ack that must not write back
    run_op(7'b0000011, 3'b010, 1'b1, 5'd11, 32'h40, 32'd0, 32'd0, -1);
    mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("late_ack_rd_we", 32'(rd_we), 32'd0);
    chk("late_ack_req", 32'(mem_req), 32'd0);

    // Reset during the second BUSY cycle
    valid_i = 1'b1; aluop_i = 7'b0000011; funct3_i = 3'b010; rd_we_i = 1'b1;
    rd_addr_i = 5'd12; rd_data_i = 32'h80;
    @(negedge clk);
    chk("rstbusy_req1", 32'(mem_req), 32'd1);
    @(negedge clk);
    rst = 1'b1; valid_i = 1'b0;
    @(negedge clk);
    chk("rstbusy_req", 32'(mem_req), 32'd0);
    chk("rstbusy_be", 32'(mem_be), 32'd0);
    chk("rstbusy_rd_we", 32'(rd_we), 32'd0);
    chk("rstbusy_stall", 32'(stall_o), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    run_op(7'b0000011, 3'b010, 1'b1, 5'd13, 32'h84, 32'd0, 32'h1357_9BDF, 0);
    chk("post_rst_lw", rd_data, 32'h1357_9BDF);

    // Randomized traffic
    for (int i = 0; i < 150; i++) begin
      r = $urandom_range(0, 9);
      a = $urandom;
      ack = $urandom_range(0, TIMEOUT);
      if (ack == TIMEOUT) ack = -1;
      if (r <= 3) op = 7'b0000011;
      else if (r <= 6) op = 7'b0100011;
      else begin
        op = 7'($urandom);
        if (op == 7'b0000011 || op == 7'b0100011) op = 7'b0010011;
      end
      if (r == 9) begin
        valid_i = 1'b0; aluop_i = op; rd_data_i = a; rd_we_i = 1'b1;
        @(negedge clk);
      end else begin
        run_op(op, 3'($urandom), 1'($urandom), 5'($urandom), a, $urandom, $urandom, ack);
      end
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Parametrised, registered successor of the pipeline MEM stage.
- Sits between EX and WB. Issues load/store transactions on a req/ack data-memory bus and formats load data (LB/LH/LW/LBU/LHU).
- Generates byte enables for SB/SH/SW, stalls upstream while a transaction is outstanding, and detects misalignment and bus timeout.
- Non-memory ops pass through to WB in one cycle; every aluop has a defined output, so no latches are inferred.

Parameters:
- XLEN, 32: data/address width; must be 32.
- REG_AW, 5: register-file address width.
- TIMEOUT, 255: maximum cycles in BUSY waiting for mem_ack before abort; minimum 1.
- TO_W, 8: width of the timeout counter; must satisfy 2^TO_W > TIMEOUT.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- valid_i  in  1  EX presents a valid instruction this cycle.
- aluop_i  in  7  opcode: 0000011 = load, 0100011 = store, anything else = non-memory.
- funct3_i  in  3  access size/sign.
- rd_we_i  in  1  writeback enable from EX.
- rd_addr_i  in  REG_AW  destination register.
- rd_data_i  in  XLEN  ALU result; the effective address for load/store.
- st_data_i  in  XLEN  store data (rs2).
- mem_req  out  1  bus request.
- mem_we  out  1  1 = store.
- mem_addr  out  XLEN  word-aligned address ({addr[31:2],2'b00}).
- mem_wdata  out  XLEN  store data replicated into byte lanes.
- mem_be  out  4  byte enables.
- mem_ack  in  1  bus completion, one-cycle pulse.
- mem_rdata  in  XLEN  read word, valid when mem_ack=1.
- stall_o  out  1  upstream must hold its inputs.
- rd_we  out  1  WB write enable (registered).
- rd_addr  out  REG_AW  WB register (registered).
- rd_data  out  XLEN  WB data (registered).
- misalign_o  out  1  one-cycle pulse: misaligned access dropped.
- bus_err_o  out  1  one-cycle pulse: bus timeout.

Behaviour:
- Reset: state=IDLE, counter=0. mem_req, mem_we, mem_be, mem_addr, mem_wdata, rd_we, rd_addr, rd_data, misalign_o and bus_err_o all 0. Reset asserted while BUSY aborts: mem_req=0 after that edge, no WB write.
- States: IDLE and BUSY.
- IDLE, valid_i=0: rd_we<=0 next edge.
- IDLE, valid_i=1, non-memory op: rd_we/rd_addr/rd_data <= inputs next edge. stall_o=0. Latency 1.
- IDLE, valid_i=1, load/store: stall_o=1 combinationally.
  - Aligned: latch op, size, address low bits and rd_addr. Drive mem_req=1 and set mem_we/mem_addr/mem_be/mem_wdata; go BUSY; counter=0. rd_we<=0.
  - Misaligned (half with addr[0]=1, word with addr[1:0]!=0, including funct3 011/110/111 treated as word): no request, rd_we<=0, misalign_o<=1 for one cycle, stay IDLE.
- BUSY: mem_req and bus outputs stay stable; valid_i and the data inputs are ignored. stall_o = ~mem_ack.
  - mem_ack=1: mem_req<=0 and go IDLE. A load writes rd_we<=latched rd_we_i, rd_addr<=latched, rd_data<=formatted data. A store gives rd_we<=0. The upstream advances on this same edge.
  - No ack: counter++. On the cycle counter==TIMEOUT-1 without ack: mem_req<=0, IDLE, rd_we<=0, bus_err_o<=1 for one cycle. stall_o drops on that cycle. A late ack arriving in IDLE is ignored.
- Load formatting: byte lane = addr[1:0], half lane = addr[1].
  - LB/LH: sign-extend.
  - LBU/LHU: zero-extend.
  - LW: the word unchanged.
- Store encoding:
  - SB: be = 0001<<addr[1:0], wdata = {4{byte}}.
  - SH: be = 0011<<(2*addr[1]), wdata = {2{half}}.
  - SW: be = 1111.
- mem_be=0 when mem_req=0.
- Minimum load latency: presented at cycle N, request at N+1, earliest ack at N+1, WB at N+2.
- Back-to-back memory ops: the next op is evaluated in the cycle after the ack edge. No overlap of transactions.

Test Plan:
- Non-memory pass-through: aluop=0110011, rd_addr=5, rd_data=0x1234 -> next cycle rd_we=1, rd_addr=5, rd_data=0x1234; mem_req stays 0; stall_o=0.
- LB at addr 0x103, ack after 3 cycles with rdata 0x80FF_FF7F: mem_addr=0x100, stall high through BUSY, WB rd_data=0xFFFF_FF80. Same access as LBU gives 0x0000_0080.
- SH at addr 0x202, st_data=0xAAAA_BEEF -> mem_we=1, mem_be=1100, mem_wdata=0xBEEF_BEEF; after ack rd_we=0.
- LW at addr 0x6 -> misalign_o pulse, no mem_req, rd_we=0, stall_o high for one cycle only.
- Timeout: LW with no ack, TIMEOUT=4 -> mem_req high exactly 4 cycles, then bus_err_o pulse, rd_we=0. An ack injected afterwards produces no WB write.
- Reset mid-BUSY: assert rst during the 2nd BUSY cycle -> next edge mem_req=0, all outputs 0. A following LW completes normally.
